mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the instruction-fetch requester (IF) and the
//  load/store requester (D) of the core, so fetch and data accesses no longer need
//  separate memories. Grants one request at a time and drives the shared port until the
//  memory accepts it. Routes the response back to the owner and recovers from a hung
//  memory via a timeout. Sits between the IF/MEM stages and the memory model.
// PARAMETERS
//  TIMEOUT  256  max cycles a granted transaction may spend in REQ+WAIT before abort
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  if_req     in   1   fetch request, held until if_gnt
//  if_addr    in   64  fetch byte address (word-aligned)
//  if_gnt     out  1   one-cycle pulse: fetch request captured
//  if_rvalid  out  1   one-cycle pulse: if_rdata valid
//  if_rdata   out  32  fetched instruction
//  d_req      in   1   data request, held until d_gnt
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   64  data byte address
//  d_wdata    in   64  store data
//  d_be       in   8   store byte enables
//  d_gnt      out  1   one-cycle pulse: data request captured
//  d_rvalid   out  1   one-cycle pulse: load data valid / store acknowledged
//  d_rdata    out  64  load data
//  m_req      out  1   shared-port request
//  m_we       out  1   shared-port write
//  m_addr     out  64  shared-port address
//  m_wdata    out  64  shared-port write data
//  m_be       out  8   shared-port byte enables (0xFF for reads)
//  m_ready    in   1   memory accepts m_req this cycle
//  m_rvalid   in   1   response valid (also write acknowledgement)
//  m_rdata    in   64  response data
//  busy       out  1   FSM not in IDLE
//  err        out  1   sticky: a transaction timed out
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): every output is 0. FSM goes to IDLE, last_owner goes to IF,
//    and the timeout counter goes to 0. Any in-flight transaction is dropped without a response.
//  - FSM states are IDLE, REQ and WAIT. All outputs are registered.
//  - IDLE: req signals are sampled only in this state. Arbitration:
//    - With one req, that requester wins.
//    - With both, the winner is the one that is not last_owner (round-robin). The first
//      conflict after reset goes to D.
//    - Capture: latch the winner's addr/we/wdata/be (IF forces we=0, be=0xFF), set owner and
//      last_owner, and pulse the winner's gnt in the next cycle. Go to REQ.
//  - REQ: m_req=1 with the latched fields, held stable until m_ready=1. On the m_ready cycle,
//    drop m_req at the next edge and go to WAIT.
//  - WAIT: on m_rvalid=1, register the response to the owner and go to IDLE.
//    - D owner: d_rdata=m_rdata.
//    - IF owner: if_rdata = addr[2] ? m_rdata[63:32] : m_rdata[31:0].
//  - m_rvalid outside WAIT is ignored. rdata outputs hold their value between rvalid pulses.
//  - Timeout: the counter clears on capture and increments each cycle in REQ/WAIT.
//    - Abort when it reaches TIMEOUT.
//    - Abort actions: drop m_req, set err=1, pulse the owner's rvalid with rdata=0, go to IDLE.
//    - An abort takes priority over m_rvalid or m_ready arriving in the same cycle.
//  - err clears only on reset.
//  - Latency with a zero-wait memory (m_ready in cycle 1, m_rvalid in cycle 2):
//    - Cycle 0: req sampled.
//    - Cycle 1: gnt, m_req.
//    - Cycle 3: rvalid.
//    - A continuously held req yields one transaction every 3 cycles.
// TESTING
//  - Fetch: if_req addr 0x1004, memory returns 0xAAAABBBBCCCCDDDD with zero wait.
//    -> if_gnt in cycle 1, m_addr=0x1004, m_we=0, if_rvalid in cycle 3 with if_rdata=0xAAAABBBB.
//  - Conflict: both reqs asserted from reset -> D granted first, then IF. A second conflict
//    -> D granted first again, since last_owner is IF after the previous IF grant.
//  - Store: d_we=1, addr 0x2000, wdata 0x1122334455667788, be 0x0F, m_ready low for 3 cycles.
//    -> m_req and all fields stable for 4 cycles; d_rvalid one cycle after m_rvalid.
//  - Timeout: TIMEOUT=16, m_ready stuck at 0.
//    -> after 16 cycles: err=1, d_rvalid pulse with d_rdata=0, busy=0; the next if_req is served.
//  - Reset in WAIT: drive rst=0 between clock edges -> all outputs 0 immediately. After release,
//    a stale m_rvalid produces no rvalid pulse.
//  - Back-to-back: if_req held high with a zero-wait memory -> if_gnt every 3 cycles and no
//    dropped or duplicated rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and
// load/store (D). One transaction in flight at a time, round-robin on conflict,
// response routed back to the owner, timeout abort on a hung memory.
module mem_port_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    // fetch requester
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    // shared memory port
    output logic        m_req,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_be,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [63:0] m_rdata,
    // status
    output logic        busy,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state;
    logic          owner_d;   // 1 = current transaction belongs to D
    logic          last_d;    // 1 = last grant went to D
    logic [CW-1:0] tcnt;
    logic          pick_d;
    logic          timeout_hit;

    // D wins when alone, or on conflict when IF held the port last
    assign pick_d      = d_req && (!if_req || !last_d);
    // tcnt counts cycles already spent; this is the TIMEOUT-th cycle in REQ/WAIT
    assign timeout_hit = (tcnt == CW'(TIMEOUT - 1));

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            tcnt      <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_be      <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        tcnt    <= '0;
                        busy    <= 1'b1;
                        m_req   <= 1'b1;
                        owner_d <= pick_d;
                        last_d  <= pick_d;
                        state   <= S_REQ;
                        if (pick_d) begin
                            d_gnt   <= 1'b1;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_be    <= d_be;
                        end else begin
                            // fetches are always full-width reads
                            if_gnt  <= 1'b1;
                            m_we    <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                            m_be    <= 8'hFF;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    tcnt <= tcnt + CW'(1);
                    if (timeout_hit) begin
                        // abort wins over a same-cycle m_ready / m_rvalid
                        m_req <= 1'b0;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end
                    end else if (state == S_REQ) begin
                        if (m_ready) begin
                            m_req <= 1'b0;
                            state <= S_WAIT;
                        end
                    end else if (m_rvalid) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= m_rdata;
                        end else begin
                            // pick the 32-bit instruction out of the 64-bit beat
                            if_rvalid <= 1'b1;
                            if_rdata  <= m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=16). Inputs change 1 time unit
// after the rising edge, outputs are checked there too.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [63:0] d_addr, d_wdata;
    logic [7:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic        m_req, m_we;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_be;
    logic        m_ready, m_rvalid;
    logic [63:0] m_rdata;
    logic        busy, err;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // zero-wait memory: accept now, respond next cycle
    task automatic serve(input logic [63:0] v);
        m_ready = 1'b1;
        tick;
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = v;
        tick;
        m_rvalid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        tests++;
        if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we,
             m_addr, m_wdata, m_be, busy, err} !== '0) begin
            $display("FAIL reset_outputs: some output nonzero (busy=%b err=%b m_req=%b m_be=%h)",
                     busy, err, m_req, m_be);
            fails++;
        end
        tick;
        tests++;
        if ({busy, m_req, if_gnt, d_gnt} !== 4'b0000) begin
            $display("FAIL reset_idle: got busy/m_req/if_gnt/d_gnt=%b want 0000",
                     {busy, m_req, if_gnt, d_gnt});
            fails++;
        end
    endtask

    task automatic test_fetch;
        if_req = 1'b1; if_addr = 64'h1004;
        tick;
        tests++;
        if ({if_gnt, d_gnt, m_req, m_we, busy} !== 5'b10101 || m_addr !== 64'h1004 || m_be !== 8'hFF) begin
            $display("FAIL fetch_grant: gnt/dgnt/mreq/mwe/busy=%b addr=%h be=%h want 10101 1004 ff",
                     {if_gnt, d_gnt, m_req, m_we, busy}, m_addr, m_be);
            fails++;
        end
        if_req = 1'b0;
        serve(64'hAAAABBBBCCCCDDDD);
        tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hAAAABBBB || busy !== 1'b0) begin
            $display("FAIL fetch_rdata: rvalid=%b rdata=%h busy=%b want 1 aaaabbbb 0",
                     if_rvalid, if_rdata, busy);
            fails++;
        end
        tick;
        tests++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'hAAAABBBB) begin
            $display("FAIL fetch_hold: rvalid=%b rdata=%h want 0 aaaabbbb", if_rvalid, if_rdata);
            fails++;
        end
    endtask

    task automatic test_conflict;
        do_reset;
        if_req = 1'b1; if_addr = 64'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3000; d_be = 8'hFF;
        tick;
        tests++;
        if ({d_gnt, if_gnt} !== 2'b10 || m_addr !== 64'h3000) begin
            $display("FAIL conflict1_d_first: d/if gnt=%b addr=%h want 10 3000", {d_gnt, if_gnt}, m_addr);
            fails++;
        end
        d_req = 1'b0;
        serve(64'h0123456789ABCDEF);
        tests++;
        if (d_rvalid !== 1'b1 || d_rdata !== 64'h0123456789ABCDEF || if_rvalid !== 1'b0) begin
            $display("FAIL conflict1_d_resp: d_rvalid=%b d_rdata=%h if_rvalid=%b want 1 0123456789abcdef 0",
                     d_rvalid, d_rdata, if_rvalid);
            fails++;
        end
        tick;
        tests++;
        if ({d_gnt, if_gnt} !== 2'b01 || m_addr !== 64'h1000) begin
            $display("FAIL conflict1_if_next: d/if gnt=%b addr=%h want 01 1000", {d_gnt, if_gnt}, m_addr);
            fails++;
        end
        if_req = 1'b0;
        serve(64'h5555666677778888);
        tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h77778888) begin
            $display("FAIL conflict1_if_resp: rvalid=%b rdata=%h want 1 77778888", if_rvalid, if_rdata);
            fails++;
        end
        // second conflict: IF owned last, so D wins again
        if_req = 1'b1; d_req = 1'b1;
        tick;
        tests++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            $display("FAIL conflict2_d_first: d/if gnt=%b want 10", {d_gnt, if_gnt});
            fails++;
        end
        d_req = 1'b0;
        serve(64'h0);
        tick;
        tests++;
        if ({d_gnt, if_gnt} !== 2'b01) begin
            $display("FAIL conflict2_if_next: d/if gnt=%b want 01", {d_gnt, if_gnt});
            fails++;
        end
        if_req = 1'b0;
        serve(64'h0);
    endtask

    task automatic test_store;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2000;
        d_wdata = 64'h1122334455667788; d_be = 8'h0F;
        m_ready = 1'b0;
        tick;
        tests++;
        if (d_gnt !== 1'b1) begin
            $display("FAIL store_grant: d_gnt=%b want 1", d_gnt);
            fails++;
        end
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({m_req, m_we} !== 2'b11 || m_addr !== 64'h2000 ||
                m_wdata !== 64'h1122334455667788 || m_be !== 8'h0F) begin
                $display("FAIL store_stable_%0d: req/we=%b addr=%h wdata=%h be=%h want 11 2000 1122334455667788 0f",
                         k, {m_req, m_we}, m_addr, m_wdata, m_be);
                fails++;
            end
            if (k < 3) tick;
        end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        tests++;
        if (m_req !== 1'b0 || d_rvalid !== 1'b0) begin
            $display("FAIL store_accept: m_req=%b d_rvalid=%b want 0 0", m_req, d_rvalid);
            fails++;
        end
        m_rvalid = 1'b1; m_rdata = 64'h0;
        tick;
        m_rvalid = 1'b0;
        tests++;
        if (d_rvalid !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL store_ack: d_rvalid=%b busy=%b want 1 0", d_rvalid, busy);
            fails++;
        end
        d_we = 1'b0;
    endtask

    task automatic test_timeout;
        // leave a nonzero d_rdata behind so the abort clearing it is visible
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3008;
        tick;
        d_req = 1'b0;
        serve(64'hDEADBEEF00000001);
        d_req = 1'b1; d_addr = 64'h4000;
        tick;
        d_req = 1'b0;
        for (int k = 0; k < 15; k++) tick;
        tests++;
        if ({m_req, busy, err, d_rvalid} !== 4'b1100) begin
            $display("FAIL timeout_before: mreq/busy/err/drvalid=%b want 1100", {m_req, busy, err, d_rvalid});
            fails++;
        end
        // late m_ready on the abort cycle must lose to the timeout
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        tests++;
        if ({m_req, busy, err, d_rvalid} !== 4'b0011 || d_rdata !== 64'h0) begin
            $display("FAIL timeout_abort: mreq/busy/err/drvalid=%b d_rdata=%h want 0011 0",
                     {m_req, busy, err, d_rvalid}, d_rdata);
            fails++;
        end
        if_req = 1'b1; if_addr = 64'h1000;
        tick;
        tests++;
        if (if_gnt !== 1'b1 || m_addr !== 64'h1000) begin
            $display("FAIL timeout_next_if: if_gnt=%b addr=%h want 1 1000", if_gnt, m_addr);
            fails++;
        end
        if_req = 1'b0;
        serve(64'h9999AAAA12345678);
        tests++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h12345678 || err !== 1'b1) begin
            $display("FAIL timeout_after: rvalid=%b rdata=%h err=%b want 1 12345678 1",
                     if_rvalid, if_rdata, err);
            fails++;
        end
    endtask

    task automatic test_reset_in_wait;
        d_req = 1'b1; d_addr = 64'h5000;
        tick;
        d_req = 1'b0;
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, m_req, m_we,
             m_addr, m_wdata, m_be, busy, err} !== '0) begin
            $display("FAIL reset_async: busy=%b err=%b m_addr=%h d_rdata=%h want all 0",
                     busy, err, m_addr, d_rdata);
            fails++;
        end
        tick;
        rst = 1'b1;
        m_rvalid = 1'b1; m_rdata = 64'hFFFF0000FFFF0000;
        tick;
        m_rvalid = 1'b0;
        tests++;
        if ({d_rvalid, if_rvalid, busy} !== 3'b000 || d_rdata !== 64'h0) begin
            $display("FAIL reset_stale_rvalid: d/if rvalid/busy=%b d_rdata=%h want 000 0",
                     {d_rvalid, if_rvalid, busy}, d_rdata);
            fails++;
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] beat;
        if_req = 1'b1; if_addr = 64'h100C;
        tick;
        for (int n = 0; n < 3; n++) begin
            beat = {32'hC0DE0000 + 32'(n), 32'h0};
            tests++;
            if (if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin
                $display("FAIL b2b_gnt_%0d: if_gnt=%b if_rvalid=%b want 1 0", n, if_gnt, if_rvalid);
                fails++;
            end
            m_ready = 1'b1;
            tick;
            m_ready = 1'b0;
            tests++;
            if (if_gnt !== 1'b0 || if_rvalid !== 1'b0) begin
                $display("FAIL b2b_mid_%0d: if_gnt=%b if_rvalid=%b want 0 0", n, if_gnt, if_rvalid);
                fails++;
            end
            m_rvalid = 1'b1; m_rdata = beat;
            tick;
            m_rvalid = 1'b0;
            tests++;
            if (if_rvalid !== 1'b1 || if_rdata !== beat[63:32] || if_gnt !== 1'b0 || d_rvalid !== 1'b0) begin
                $display("FAIL b2b_resp_%0d: rvalid=%b rdata=%h gnt=%b want 1 %h 0",
                         n, if_rvalid, if_rdata, if_gnt, beat[63:32]);
                fails++;
            end
            if (n == 2) if_req = 1'b0;
            tick;
        end
        tests++;
        if ({if_gnt, if_rvalid, busy} !== 3'b000) begin
            $display("FAIL b2b_end: gnt/rvalid/busy=%b want 000", {if_gnt, if_rvalid, busy});
            fails++;
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_conflict;
        test_store;
        test_timeout;
        test_reset_in_wait;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
